unidad_condicional_flags: RTL

//  Stage directly downstream of unidad_logico_aritmetica. Holds architectural NZCV register, evaluates
//  4-bit ARM cond field against it, gates regWrite/memWrite, updates NZCV when S bit set, and

---
 rtl/cond_pkg.sv | 27 ++
 rtl/evaluador_condicion.sv | 36 +++
 rtl/unidad_condicional_flags.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cond_pkg.sv
// Shared types for the conditional-flags stage.
//   cond_e   : ARM 4-bit condition field encodings (EQ..NV)
//   nzcv_t   : architectural flag register layout {n,z,c,v}, MSB first
//   estado_e : handshake occupancy state (0, 1 or 2 buffered entries)
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef enum logic [1:0] {
    VACIO    = 2'd0,
    LLENO    = 2'd1,
    DESBORDE = 2'd2
  } estado_e;

endpackage

// File: rtl/evaluador_condicion.sv
// Combinational ARM condition evaluator.
//   cond   in  4  condition field
//   flags  in  4  current NZCV (nzcv_t)
//   cond_ex out 1 1 = instruction executes
module evaluador_condicion
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  nzcv_t      flags,
  output logic       cond_ex
);

  always_comb begin
    cond_ex = 1'b0;
    case (cond_e'(cond))
      EQ: cond_ex = flags.z;
      NE: cond_ex = !flags.z;
      CS: cond_ex = flags.c;
      CC: cond_ex = !flags.c;
      MI: cond_ex = flags.n;
      PL: cond_ex = !flags.n;
      VS: cond_ex = flags.v;
      VC: cond_ex = !flags.v;
      HI: cond_ex = flags.c & !flags.z;
      LS: cond_ex = !flags.c | flags.z;
      GE: cond_ex = (flags.n == flags.v);
      LT: cond_ex = (flags.n != flags.v);
      GT: cond_ex = !flags.z & (flags.n == flags.v);
      LE: cond_ex = flags.z | (flags.n != flags.v);
      AL: cond_ex = 1'b1;
      NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/unidad_condicional_flags.sv
// Conditional-execution / flags stage behind the ALU.
// Holds the NZCV register, evaluates the ARM cond field against it, gates
// regWrite/memWrite, updates NZCV on executed S-bit instructions and hands the
// result to writeback through a valid/ready handshake with a 2-entry skid.
// Ports:
//   clk, reset (sync, active-high)
//   in_valid/in_ready, resultado[N], flagNegativo/Cero/Overflow/Carry, cond[4],
//   flagWrite, regWrite, memWrite, rd[4]                  -- from ALU
//   out_valid/out_ready, out_resultado[N], out_rd[4], out_regWrite,
//   out_memWrite, out_condEx                              -- to writeback
//   nzcv[4] {N,Z,C,V}
// Optional: COND_STATS_EN adds cnt_exec[STAT_W] / cnt_squash[STAT_W].
module unidad_condicional_flags
  import cond_pkg::*;
#(
  parameter int N      = 32,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      resultado,
  input  logic              flagNegativo,
  input  logic              flagCero,
  input  logic              flagOverflow,
  input  logic              flagCarry,
  input  logic [3:0]        cond,
  input  logic              flagWrite,
  input  logic              regWrite,
  input  logic              memWrite,
  input  logic [3:0]        rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_resultado,
  output logic [3:0]        out_rd,
  output logic              out_regWrite,
  output logic              out_memWrite,
  output logic              out_condEx,
`ifdef COND_STATS_EN
  output logic [STAT_W-1:0] cnt_exec,
  output logic [STAT_W-1:0] cnt_squash,
`endif
  output logic [3:0]        nzcv
);

  // Entry width follows N, so the entry type lives next to the parameter.
  typedef struct packed {
    logic [N-1:0] resultado;
    logic [3:0]   rd;
    logic         regWrite;
    logic         memWrite;
    logic         condEx;
  } wb_entry_t;

  estado_e   estado;
  nzcv_t     nzcv_q;
  wb_entry_t out_e, skid_e, in_e;
  logic      cond_ex, accept;

  evaluador_condicion u_eval (
    .cond    (cond),
    .flags   (nzcv_q),
    .cond_ex (cond_ex)
  );

  assign accept = in_valid & in_ready;

  always_comb begin
    in_e.resultado = resultado;
    in_e.rd        = rd;
    in_e.regWrite  = regWrite & cond_ex;
    in_e.memWrite  = memWrite & cond_ex;
    in_e.condEx    = cond_ex;
  end

  // in_ready is its own flop so out_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado    <= VACIO;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_e     <= '0;
      skid_e    <= '0;
      nzcv_q    <= '0;
    end else begin
      if (accept && cond_ex && flagWrite)
        nzcv_q <= '{n: flagNegativo, z: flagCero, c: flagCarry, v: flagOverflow};
      case (estado)
        VACIO: begin
          if (accept) begin
            out_e     <= in_e;
            out_valid <= 1'b1;
            estado    <= LLENO;
          end
        end
        LLENO: begin
          if (accept && out_ready) begin
            out_e <= in_e;
          end else if (accept) begin
            skid_e   <= in_e;
            in_ready <= 1'b0;
            estado   <= DESBORDE;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            estado    <= VACIO;
          end
        end
        DESBORDE: begin
          if (out_ready) begin
            out_e    <= skid_e;
            in_ready <= 1'b1;
            estado   <= LLENO;
          end
        end
        default: begin
          estado    <= VACIO;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_resultado = out_e.resultado;
  assign out_rd        = out_e.rd;
  assign out_regWrite  = out_e.regWrite;
  assign out_memWrite  = out_e.memWrite;
  assign out_condEx    = out_e.condEx;
  assign nzcv          = nzcv_q;

`ifdef COND_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_exec   <= '0;
      cnt_squash <= '0;
    end else if (accept) begin
      if (cond_ex) cnt_exec   <= cnt_exec + 1'b1;
      else         cnt_squash <= cnt_squash + 1'b1;
    end
  end
`endif

endmodule
